// File: rtl/axi4_master_engine.sv
// Single-outstanding AXI4 initiator: one write (AW/W/B) or read (AR/R) burst per command,
// with streaming local write source / read sink and a per-command completion status.
module axi4_master_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] MaxSize = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    StIdle, StWaddr, StWdata, StWresp, StRaddr, StRdata, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [2:0]            size_q, size_d;
  logic                  bad_q, bad_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  last_beat;
  logic                  size_bad;

  assign last_beat = (beat_q == len_q);
  assign size_bad  = (cmd_size > MaxSize);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      bad_q   <= 1'b0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      size_q  <= size_d;
      bad_q   <= bad_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    size_d     = size_q;
    bad_d      = bad_q;
    resp_d     = resp_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    wr_ready   = 1'b0;
    BREADY     = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    rd_valid   = 1'b0;
    done_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = ~ARESET;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          beat_d  = '0;
          bad_d   = size_bad;
          resp_d  = size_bad ? 2'b10 : 2'b00;
          err_d   = 1'b0;
          state_d = cmd_write ? StWaddr : StRaddr;
        end
      end
      // An oversized beat skips the bus entirely but still costs this one cycle.
      StWaddr: begin
        if (bad_q) begin
          state_d = StDone;
        end else begin
          AWVALID = 1'b1;
          if (AWREADY) state_d = StWdata;
        end
      end
      StWdata: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        if (wr_valid && WREADY) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = StWresp;
        end
      end
      StWresp: begin
        BREADY = 1'b1;
        if (BVALID) begin
          if (BRESP > resp_q) resp_d = BRESP;
          state_d = StDone;
        end
      end
      StRaddr: begin
        if (bad_q) begin
          state_d = StDone;
        end else begin
          ARVALID = 1'b1;
          if (ARREADY) state_d = StRdata;
        end
      end
      // Beat count, not RLAST, ends the burst; a disagreeing RLAST is only flagged.
      StRdata: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        if (RVALID && rd_ready) begin
          if (RRESP > resp_q) resp_d = RRESP;
          if (RLAST != last_beat) err_d = 1'b1;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = StDone;
        end
      end
      StDone: begin
        done_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = size_q;
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = size_q;
  assign WDATA     = wr_data;
  assign WLAST     = (state_q == StWdata) && last_beat;
  assign rd_data   = RDATA;
  assign rd_last   = (state_q == StRdata) && last_beat;
  assign done_resp = resp_q;
  assign done_err  = err_q;

endmodule

// File: tb/tb_axi4_master_engine.sv
// Randomized bench for axi4_master_engine: a reactive AXI slave/source/sink environment plus a
// scoreboard holding the expected memory image, data order and completion status per command.
module tb_axi4_master_engine;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic        done_valid, done_err;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_master_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment configuration
  bit          stall;
  logic [1:0]  bresp_cfg;
  logic [1:0]  rresp_arr [0:255];
  int          rlast_beat;
  int          rlast_override;

  logic [31:0] smem      [0:1023];
  logic [31:0] model_mem [0:1023];
  logic [31:0] src_q[$], obs_w[$], obs_r[$];
  bit          obs_wlast[$], obs_rlast[$];

  int          aw_cnt, ar_cnt, axv_cnt, stab_err, wb4aw;
  int          done_cnt, cyc, last_hs_cyc, done_cyc;
  logic [15:0] aw_addr_o, ar_addr_o;
  logic [7:0]  aw_len_o, ar_len_o;
  logic [2:0]  aw_size_o, ar_size_o;
  logic [1:0]  done_resp_o;
  logic        done_err_o;

  int          wbase, wbeat, w_exp, rbase, rbeat, r_rem;
  bit          b_pend, src_hs, b_hs, r_hs;
  bit          aw_st, ar_st, w_st;
  logic [15:0] aw_pa, ar_pa;
  logic [7:0]  aw_pl, ar_pl;
  logic [2:0]  aw_ps, ar_ps;
  logic [31:0] w_pd;
  logic        w_pl;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave, write source and read sink: observe at negedge, drive just after posedge.
  initial begin : env
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0; RVALID = 0;
    RDATA = 0; RRESP = 0; RLAST = 0; wr_valid = 0; wr_data = 0; rd_ready = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      src_hs = 0; b_hs = 0; r_hs = 0;
      if (!ARESET) begin
        if (AWVALID || ARVALID) axv_cnt++;
        if (aw_st && (!AWVALID || AWADDR !== aw_pa || AWLEN !== aw_pl || AWSIZE !== aw_ps))
          stab_err++;
        aw_st = AWVALID && !AWREADY; aw_pa = AWADDR; aw_pl = AWLEN; aw_ps = AWSIZE;
        if (ar_st && (!ARVALID || ARADDR !== ar_pa || ARLEN !== ar_pl || ARSIZE !== ar_ps))
          stab_err++;
        ar_st = ARVALID && !ARREADY; ar_pa = ARADDR; ar_pl = ARLEN; ar_ps = ARSIZE;
        if (w_st && (!WVALID || WDATA !== w_pd || WLAST !== w_pl)) stab_err++;
        w_st = WVALID && !WREADY; w_pd = WDATA; w_pl = WLAST;
        if (WVALID && aw_cnt == 0) wb4aw++;
        if (AWVALID && AWREADY) begin
          aw_cnt++; aw_addr_o = AWADDR; aw_len_o = AWLEN; aw_size_o = AWSIZE;
          wbase = int'(AWADDR[11:2]); wbeat = 0; w_exp = int'(AWLEN) + 1;
        end
        if (WVALID && WREADY) begin
          obs_w.push_back(WDATA); obs_wlast.push_back(WLAST);
          smem[(wbase + wbeat) % 1024] = WDATA;
          wbeat++;
          if (wbeat == w_exp) b_pend = 1;
        end
        if (wr_valid && wr_ready) begin
          src_hs = 1;
          if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (BVALID && BREADY) begin b_hs = 1; last_hs_cyc = cyc; end
        if (ARVALID && ARREADY) begin
          ar_cnt++; ar_addr_o = ARADDR; ar_len_o = ARLEN; ar_size_o = ARSIZE;
          rbase = int'(ARADDR[11:2]); rbeat = 0; r_rem = int'(ARLEN) + 1;
        end
        if (RVALID && RREADY) begin r_hs = 1; rbeat++; r_rem--; last_hs_cyc = cyc; end
        if (rd_valid && rd_ready) begin obs_r.push_back(rd_data); obs_rlast.push_back(rd_last); end
        if (done_valid) begin
          done_cnt++; done_cyc = cyc; done_resp_o = done_resp; done_err_o = done_err;
        end
      end
      @(posedge ACLK); #1;
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; wr_valid = 0; rd_ready = 0;
        src_q.delete(); b_pend = 0; r_rem = 0; aw_st = 0; ar_st = 0; w_st = 0;
      end else begin
        AWREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        ARREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        WREADY   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(wr_valid && !src_hs)) begin
          if (src_q.size() > 0) begin
            wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = src_q[0];
          end else begin
            wr_valid = 0;
          end
        end
        if (BVALID && b_hs) BVALID = 0;
        else if (b_pend && !BVALID && (!stall || $urandom_range(0, 1) == 1)) begin
          BVALID = 1; BRESP = bresp_cfg; b_pend = 0;
        end
        if (!(RVALID && !r_hs)) begin
          if (r_rem > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
            RVALID = 1;
            RDATA  = smem[(rbase + rbeat) % 1024];
            RLAST  = (rbeat == rlast_beat);
            RRESP  = rresp_arr[rbeat];
          end else begin
            RVALID = 0;
          end
        end
      end
    end
  end

  task automatic send_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size);
    bit hs = 0;
    int guard = 0;
    @(posedge ACLK); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
    while (!hs && guard < 50) begin
      @(negedge ACLK); #1;
      hs = cmd_ready;
      @(posedge ACLK); #1;
      guard++;
    end
    cmd_valid = 0;
    check_eq("cmd_accept", 64'(hs), 64'd1);
  endtask

  task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [31:0] base);
    int          n = int'(len) + 1;
    logic [31:0] exp_d[$];
    logic [31:0] d;
    logic [1:0]  exp_resp = 2'b00;
    bit          exp_err = 0;
    bit          bad = (size > 3'd2);
    bit          first_v = 0;
    int          lat = 0;
    int          d0;
    int          wl_bad = 0;
    int          rl_bad = 0;
    obs_w.delete(); obs_wlast.delete(); obs_r.delete(); obs_rlast.delete();
    aw_cnt = 0; ar_cnt = 0; axv_cnt = 0; stab_err = 0; wb4aw = 0;
    rlast_beat = (rlast_override >= 0) ? rlast_override : int'(len);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        d = (base != 0) ? base + 32'(i) : $urandom;
        exp_d.push_back(d);
        if (!bad) src_q.push_back(d);
      end
      exp_resp = bresp_cfg;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_d.push_back(model_mem[(int'(addr[11:2]) + i) % 1024]);
        if (rresp_arr[i] > exp_resp) exp_resp = rresp_arr[i];
        if ((i == rlast_beat) != (i == int'(len))) exp_err = 1;
      end
    end
    if (bad) begin exp_resp = 2'b10; exp_err = 0; end

    send_cmd(wr, addr, len, size);
    d0 = done_cnt;
    while (done_cnt == d0 && lat < 3000) begin
      @(negedge ACLK); #1;
      lat++;
      if (lat == 1) first_v = wr ? AWVALID : ARVALID;
    end
    check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
    check_eq("done_resp", 64'(done_resp_o), 64'(exp_resp));
    check_eq("done_err", 64'(done_err_o), 64'(exp_err));
    if (bad) begin
      check_eq("bad_size_latency", 64'(lat), 64'd2);
      check_eq("bad_size_no_axvalid", 64'(axv_cnt), 64'd0);
    end else begin
      check_eq("axvalid_next_cycle", 64'(first_v), 64'd1);
      check_eq("done_after_last_hs", 64'(done_cyc - last_hs_cyc), 64'd1);
    end
    @(negedge ACLK); #1;
    check_eq("pulse_then_ready", {62'd0, done_valid, cmd_ready}, 64'd1);
    check_eq("stable_while_stalled", 64'(stab_err), 64'd0);
    check_eq("no_w_before_aw", 64'(wb4aw), 64'd0);
    if (!bad && wr) begin
      check_eq("aw_count", 64'(aw_cnt), 64'd1);
      check_eq("aw_fields", {aw_addr_o, aw_len_o, aw_size_o}, {addr, len, size});
      check_eq("w_beats", 64'(obs_w.size()), 64'(n));
      for (int i = 0; i < n && i < obs_w.size(); i++) begin
        check_eq($sformatf("wdata[%0d]", i), 64'(obs_w[i]), 64'(exp_d[i]));
        if (obs_wlast[i] != (i == n - 1)) wl_bad++;
      end
      check_eq("wlast_position", 64'(wl_bad), 64'd0);
      for (int i = 0; i < n; i++) model_mem[(int'(addr[11:2]) + i) % 1024] = exp_d[i];
    end else if (!bad) begin
      check_eq("ar_count", 64'(ar_cnt), 64'd1);
      check_eq("ar_fields", {ar_addr_o, ar_len_o, ar_size_o}, {addr, len, size});
      check_eq("r_beats", 64'(obs_r.size()), 64'(n));
      for (int i = 0; i < n && i < obs_r.size(); i++) begin
        check_eq($sformatf("rdata[%0d]", i), 64'(obs_r[i]), 64'(exp_d[i]));
        if (obs_rlast[i] != (i == n - 1)) rl_bad++;
      end
      check_eq("rd_last_position", 64'(rl_bad), 64'd0);
    end
  endtask

  initial begin : main
    int          d0;
    int          guard;
    logic [15:0] a;
    logic [7:0]  l;
    for (int i = 0; i < 1024; i++) begin smem[i] = '0; model_mem[i] = '0; end
    for (int i = 0; i < 256; i++) rresp_arr[i] = 2'b00;
    stall = 0; bresp_cfg = 0; rlast_override = -1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); #1;
    check_eq("reset_valids", {56'd0, cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY,
                              rd_valid, done_valid}, 64'd0);
    check_eq("reset_ax_regs", {AWADDR, AWLEN, AWSIZE, ARADDR, ARLEN, ARSIZE}, 64'd0);
    ARESET = 0;
    @(negedge ACLK); #1;
    check_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Fixed-pattern write then read-back, no stalls
    run_cmd(1, 16'h0010, 8'd3, 3'd2, 32'hA0);
    run_cmd(0, 16'h0010, 8'd3, 3'd2, 32'h0);

    // Random stalls on every channel, random lengths and responses
    stall = 1;
    for (int k = 0; k < 6; k++) begin
      a = {4'd0, 10'($urandom_range(0, 767)), 2'b00};
      l = (k == 0) ? 8'd15 : 8'($urandom_range(0, 15));
      bresp_cfg = 2'($urandom_range(0, 3));
      for (int i = 0; i < 256; i++) rresp_arr[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      run_cmd(1, a, l, 3'd2, 32'h0);
      run_cmd(0, a, l, 3'd2, 32'h0);
    end
    stall = 0; bresp_cfg = 0;
    for (int i = 0; i < 256; i++) rresp_arr[i] = 2'b00;

    // Early RLAST and one SLVERR beat
    rlast_override = 2;
    rresp_arr[1] = 2'b10;
    run_cmd(0, 16'h0010, 8'd3, 3'd2, 32'h0);
    rlast_override = -1;
    rresp_arr[1] = 2'b00;

    // Oversized beat size
    run_cmd(1, 16'h0040, 8'd3, 3'd3, 32'h0);
    run_cmd(0, 16'h0040, 8'd0, 3'd5, 32'h0);

    // Maximum burst
    run_cmd(1, 16'h0400, 8'd255, 3'd2, 32'h0);
    run_cmd(0, 16'h0400, 8'd255, 3'd2, 32'h0);

    // Reset in the middle of an 8-beat write
    for (int i = 0; i < 8; i++) src_q.push_back(32'hC000 + 32'(i));
    obs_w.delete(); obs_wlast.delete(); aw_cnt = 0;
    send_cmd(1, 16'h0080, 8'd7, 3'd2);
    guard = 0;
    while (obs_w.size() < 2 && guard < 100) begin @(negedge ACLK); #2; guard++; end
    check_eq("reached_beat2", 64'(obs_w.size()), 64'd2);
    d0 = done_cnt;
    ARESET = 1;
    #1;
    check_eq("async_drop", {59'd0, WVALID, AWVALID, BREADY, wr_ready, cmd_ready}, 64'd0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 0;
    #1;
    check_eq("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
    run_cmd(1, 16'h0080, 8'd7, 3'd2, 32'h0);
    run_cmd(0, 16'h0080, 8'd7, 3'd2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
